// File: rtl/jtag_tap_param.sv
// jtag_tap_param: parametrised IEEE 1149.1-style TAP controller.
// 16-state TMS FSM (state visible on tap_state), instruction register with
// capture/shift/update, IDCODE / BYPASS / USER_COUNT user data registers.
// User registers are captured from core logic and written back on UpdDR.
// Optional build macro JTAG_TAP_IR_STATUS_EN adds a sticky ir_invalid bit
// reported in bit 2 of the IR capture value (needs IR_WIDTH >= 3).
// All state changes on posedge tck; trst is a synchronous active-high reset.
module jtag_tap_param #(
  parameter int                  IR_WIDTH       = 4,
  parameter logic [31:0]         IDCODE_VALUE   = 32'h000FAF01,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSN    = 4'b1110,
  parameter int                  USER_COUNT     = 2,
  parameter int                  USER_WIDTH     = 8,
  parameter logic [IR_WIDTH-1:0] USER_INSN_BASE = 4'b0100
) (
  input  logic                             tck,
  input  logic                             trst,
  input  logic                             tms,
  input  logic                             tdi,
  output logic                             tdo,
  output logic                             tdo_en,
  output logic [3:0]                       tap_state,
  output logic [IR_WIDTH-1:0]              ir_value,
  input  logic [USER_COUNT*USER_WIDTH-1:0] user_dr_in,
  output logic [USER_COUNT*USER_WIDTH-1:0] user_dr_out,
  output logic [USER_COUNT-1:0]            user_update
);

  localparam int                  UW_ALL      = USER_COUNT * USER_WIDTH;
  localparam logic [IR_WIDTH-1:0] BYPASS_INSN = '1;

  localparam logic [3:0] S_TLR   = 4'd0;
  localparam logic [3:0] S_RTI   = 4'd1;
  localparam logic [3:0] S_SELDR = 4'd2;
  localparam logic [3:0] S_SELIR = 4'd3;
  localparam logic [3:0] S_CAPDR = 4'd4;
  localparam logic [3:0] S_CAPIR = 4'd5;
  localparam logic [3:0] S_SHDR  = 4'd6;
  localparam logic [3:0] S_SHIR  = 4'd7;
  localparam logic [3:0] S_EX1DR = 4'd8;
  localparam logic [3:0] S_EX1IR = 4'd9;
  localparam logic [3:0] S_PAUDR = 4'd10;
  localparam logic [3:0] S_PAUIR = 4'd11;
  localparam logic [3:0] S_EX2DR = 4'd12;
  localparam logic [3:0] S_EX2IR = 4'd13;
  localparam logic [3:0] S_UPDDR = 4'd14;
  localparam logic [3:0] S_UPDIR = 4'd15;

  logic [3:0]            state_q,       state_d;
  logic [IR_WIDTH-1:0]   ir_value_q,    ir_value_d;
  logic [IR_WIDTH-1:0]   ir_shift_q,    ir_shift_d;
  logic [31:0]           idcode_sr_q,   idcode_sr_d;
  logic                  bypass_q,      bypass_d;
  logic [USER_WIDTH-1:0] user_sr_q,     user_sr_d;
  logic [UW_ALL-1:0]     user_dr_out_q, user_dr_out_d;
  logic [USER_COUNT-1:0] user_update_q, user_update_d;
`ifdef JTAG_TAP_IR_STATUS_EN
  logic                  ir_invalid_q,  ir_invalid_d;
`endif

  logic                  sel_idcode;
  logic                  sel_user;
  logic [1:0]            user_idx;
  logic [IR_WIDTH-1:0]   ir_cap;

`ifdef JTAG_TAP_IR_STATUS_EN
  // True when opc selects IDCODE, BYPASS or an implemented user register.
  function automatic logic opc_known(input logic [IR_WIDTH-1:0] opc);
    logic hit;
    hit = (opc == IDCODE_INSN) || (opc == BYPASS_INSN);
    for (int k = 0; k < USER_COUNT; k++) begin
      if (opc == USER_INSN_BASE + IR_WIDTH'(k)) hit = 1'b1;
    end
    return hit;
  endfunction
`endif

  // Standard 1149.1 TMS graph.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TLR:   state_d = tms ? S_TLR   : S_RTI;
      S_RTI:   state_d = tms ? S_SELDR : S_RTI;
      S_SELDR: state_d = tms ? S_SELIR : S_CAPDR;
      S_SELIR: state_d = tms ? S_TLR   : S_CAPIR;
      S_CAPDR: state_d = tms ? S_EX1DR : S_SHDR;
      S_CAPIR: state_d = tms ? S_EX1IR : S_SHIR;
      S_SHDR:  state_d = tms ? S_EX1DR : S_SHDR;
      S_SHIR:  state_d = tms ? S_EX1IR : S_SHIR;
      S_EX1DR: state_d = tms ? S_UPDDR : S_PAUDR;
      S_EX1IR: state_d = tms ? S_UPDIR : S_PAUIR;
      S_PAUDR: state_d = tms ? S_EX2DR : S_PAUDR;
      S_PAUIR: state_d = tms ? S_EX2IR : S_PAUIR;
      S_EX2DR: state_d = tms ? S_UPDDR : S_SHDR;
      S_EX2IR: state_d = tms ? S_UPDIR : S_SHIR;
      S_UPDDR: state_d = tms ? S_SELDR : S_RTI;
      S_UPDIR: state_d = tms ? S_SELDR : S_RTI;
      default: state_d = S_TLR;
    endcase
  end

  // Decode the active instruction into a DR select; IDCODE and all-ones win
  // over any user opcode that happens to alias them.
  always_comb begin
    sel_idcode = (ir_value_q == IDCODE_INSN);
    sel_user   = 1'b0;
    user_idx   = 2'd0;
    if (!sel_idcode && (ir_value_q != BYPASS_INSN)) begin
      for (int k = 0; k < USER_COUNT; k++) begin
        if (ir_value_q == USER_INSN_BASE + IR_WIDTH'(k)) begin
          sel_user = 1'b1;
          user_idx = 2'(k);
        end
      end
    end
  end

  // IR capture pattern: fixed 01 in the low bits, status bit 2 when enabled.
  always_comb begin
    ir_cap    = '0;
    ir_cap[0] = 1'b1;
`ifdef JTAG_TAP_IR_STATUS_EN
    ir_cap[2] = ir_invalid_q;
`endif
  end

  // Register datapath: capture, shift and update actions keyed on the state
  // being left at this edge. Pause/Exit states fall through and hold.
  always_comb begin
    ir_value_d    = ir_value_q;
    ir_shift_d    = ir_shift_q;
    idcode_sr_d   = idcode_sr_q;
    bypass_d      = bypass_q;
    user_sr_d     = user_sr_q;
    user_dr_out_d = user_dr_out_q;
    user_update_d = '0;
`ifdef JTAG_TAP_IR_STATUS_EN
    ir_invalid_d  = ir_invalid_q;
`endif
    case (state_q)
      S_TLR: begin
        ir_value_d = IDCODE_INSN;
`ifdef JTAG_TAP_IR_STATUS_EN
        ir_invalid_d = 1'b0;
`endif
      end
      S_CAPIR: ir_shift_d = ir_cap;
      S_SHIR: begin
        ir_shift_d = ir_shift_q >> 1;
        ir_shift_d[IR_WIDTH-1] = tdi;
      end
      S_UPDIR: begin
        ir_value_d = ir_shift_q;
`ifdef JTAG_TAP_IR_STATUS_EN
        if (!opc_known(ir_shift_q)) ir_invalid_d = 1'b1;
`endif
      end
      S_CAPDR: begin
        if (sel_idcode) begin
          idcode_sr_d = IDCODE_VALUE;
        end else if (sel_user) begin
          for (int k = 0; k < USER_COUNT; k++) begin
            if (user_idx == 2'(k)) user_sr_d = user_dr_in[k*USER_WIDTH +: USER_WIDTH];
          end
        end else begin
          bypass_d = 1'b0;
        end
      end
      S_SHDR: begin
        if (sel_idcode) begin
          idcode_sr_d = idcode_sr_q >> 1;
          idcode_sr_d[31] = tdi;
        end else if (sel_user) begin
          user_sr_d = user_sr_q >> 1;
          user_sr_d[USER_WIDTH-1] = tdi;
        end else begin
          bypass_d = tdi;
        end
      end
      S_UPDDR: begin
        if (sel_user) begin
          for (int k = 0; k < USER_COUNT; k++) begin
            if (user_idx == 2'(k)) begin
              user_dr_out_d[k*USER_WIDTH +: USER_WIDTH] = user_sr_q;
              user_update_d[k] = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // State and register flops with synchronous reset.
  always_ff @(posedge tck) begin
    if (trst) begin
      state_q       <= S_TLR;
      ir_value_q    <= IDCODE_INSN;
      ir_shift_q    <= '0;
      idcode_sr_q   <= '0;
      bypass_q      <= 1'b0;
      user_sr_q     <= '0;
      user_dr_out_q <= '0;
      user_update_q <= '0;
`ifdef JTAG_TAP_IR_STATUS_EN
      ir_invalid_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ir_value_q    <= ir_value_d;
      ir_shift_q    <= ir_shift_d;
      idcode_sr_q   <= idcode_sr_d;
      bypass_q      <= bypass_d;
      user_sr_q     <= user_sr_d;
      user_dr_out_q <= user_dr_out_d;
      user_update_q <= user_update_d;
`ifdef JTAG_TAP_IR_STATUS_EN
      ir_invalid_q  <= ir_invalid_d;
`endif
    end
  end

  // tdo mux: first bit of the selected register is visible in the first
  // shift cycle, so it is combinational from the current state.
  always_comb begin
    tdo    = 1'b0;
    tdo_en = 1'b0;
    if (state_q == S_SHIR) begin
      tdo    = ir_shift_q[0];
      tdo_en = 1'b1;
    end else if (state_q == S_SHDR) begin
      tdo_en = 1'b1;
      if (sel_idcode)    tdo = idcode_sr_q[0];
      else if (sel_user) tdo = user_sr_q[0];
      else               tdo = bypass_q;
    end
  end

  assign tap_state   = state_q;
  assign ir_value    = ir_value_q;
  assign user_dr_out = user_dr_out_q;
  assign user_update = user_update_q;

endmodule
